// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: raster timing, video preamble/guard band, and a
// once-per-line data island slot shared round-robin among packet sources.
// Every output is registered and describes the x/y presented in that cycle.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int NUM_REQ    = 2,
    parameter int ISL_OFFSET = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] pkt_req,
    output logic [NUM_REQ-1:0] pkt_grant,
    output logic [4:0]         pkt_idx,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic               hSync,
    output logic               vSync,
    output logic               VDE,
    output logic               ADE,
    output logic               vid_pre,
    output logic               vid_gb,
    output logic               isl_pre,
    output logic               isl_gb
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_BLANK = H_TOTAL - H_ACTIVE;
    localparam int IS      = H_ACTIVE + ISL_OFFSET;

    // Island = 8 preamble + 2 guard + 32 packet + 2 guard, and it must still
    // leave 12 control clocks plus the 10-clock video preamble/guard band.
    localparam bit ISL_EN = (H_BLANK >= ISL_OFFSET + 44 + 12 + 10);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [11:0] HT_M1 = 12'(H_TOTAL - 1);
    localparam logic [11:0] VT_M1 = 12'(V_TOTAL - 1);
    localparam logic [11:0] HA    = 12'(H_ACTIVE);
    localparam logic [11:0] VA    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_B  = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0] HS_E  = 12'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] VS_B  = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0] VS_E  = 12'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [11:0] VP_B  = 12'(H_TOTAL - 10);
    localparam logic [11:0] VP_E  = 12'(H_TOTAL - 3);
    localparam logic [11:0] VG_B  = 12'(H_TOTAL - 2);
    localparam logic [11:0] IS_M1 = 12'(IS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_LGB,
        ST_PKT,
        ST_TGB
    } state_t;

    state_t               state_reg;
    logic [5:0]           phase_reg;
    logic [PW-1:0]        ptr_reg;

    logic [11:0]          x_next;
    logic [11:0]          y_next;
    logic [11:0]          y_succ;
    logic                 succ_active;

    logic                 req_any;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [PW-1:0]        sel_idx;
    logic [PW-1:0]        ptr_adv;

    // Next raster position; outputs are decoded from it so that they line up
    // with the registered x/y they are launched together with.
    always_comb begin
        x_next = x + 12'd1;
        y_next = y;
        if (x == HT_M1) begin
            x_next = 12'd0;
            y_next = (y == VT_M1) ? 12'd0 : y + 12'd1;
        end
        y_succ      = (y_next == VT_M1) ? 12'd0 : y_next + 12'd1;
        succ_active = (y_succ < VA);
    end

    // Round-robin pick: first requester at or after the pointer, wrapping.
    always_comb begin
        int k;
        sel_onehot = '0;
        sel_idx    = '0;
        req_any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_reg) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!req_any && pkt_req[k]) begin
                req_any       = 1'b1;
                sel_idx       = PW'(k);
                sel_onehot[k] = 1'b1;
            end
        end
        ptr_adv = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    // Raster counters and the video timing flags derived from them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            VDE     <= 1'b0;
            hSync   <= 1'b0;
            vSync   <= 1'b0;
            vid_pre <= 1'b0;
            vid_gb  <= 1'b0;
        end else begin
            x       <= x_next;
            y       <= y_next;
            VDE     <= (x_next < HA) && (y_next < VA);
            hSync   <= (x_next >= HS_B) && (x_next <= HS_E);
            vSync   <= (y_next >= VS_B) && (y_next <= VS_E);
            vid_pre <= succ_active && (x_next >= VP_B) && (x_next <= VP_E);
            vid_gb  <= succ_active && (x_next >= VG_B);
        end
    end

    // Data island sequencer: one slot per line, decided in the cycle before
    // the slot starts; the grant is held until the trailing guard band ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            phase_reg <= '0;
            ptr_reg   <= '0;
            pkt_grant <= '0;
            pkt_idx   <= '0;
            isl_pre   <= 1'b0;
            isl_gb    <= 1'b0;
            ADE       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (ISL_EN && (x == IS_M1) && req_any) begin
                        state_reg <= ST_PRE;
                        phase_reg <= '0;
                        ptr_reg   <= ptr_adv;
                        pkt_grant <= sel_onehot;
                        isl_pre   <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (phase_reg == 6'd7) begin
                        state_reg <= ST_LGB;
                        phase_reg <= '0;
                        isl_pre   <= 1'b0;
                        isl_gb    <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 6'd1;
                    end
                end
                ST_LGB: begin
                    if (phase_reg == 6'd1) begin
                        state_reg <= ST_PKT;
                        phase_reg <= '0;
                        isl_gb    <= 1'b0;
                        ADE       <= 1'b1;
                        pkt_idx   <= '0;
                    end else begin
                        phase_reg <= phase_reg + 6'd1;
                    end
                end
                ST_PKT: begin
                    if (phase_reg == 6'd31) begin
                        state_reg <= ST_TGB;
                        phase_reg <= '0;
                        ADE       <= 1'b0;
                        pkt_idx   <= '0;
                        isl_gb    <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + 6'd1;
                        pkt_idx   <= phase_reg[4:0] + 5'd1;
                    end
                end
                ST_TGB: begin
                    if (phase_reg == 6'd1) begin
                        state_reg <= ST_IDLE;
                        phase_reg <= '0;
                        isl_gb    <= 1'b0;
                        pkt_grant <= '0;
                    end else begin
                        phase_reg <= phase_reg + 6'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    phase_reg <= '0;
                    pkt_grant <= '0;
                    pkt_idx   <= '0;
                    isl_pre   <= 1'b0;
                    isl_gb    <= 1'b0;
                    ADE       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler with default horizontal timing
// and a short frame so several full frames fit in a brief run.
module tb_hdmi_period_scheduler;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 8, VF = 2, VS = 2, VB = 3;
    localparam int NR = 2, IO = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int IS = HA + IO;

    typedef logic [38:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [NR-1:0] pkt_req;
    logic [NR-1:0] pkt_grant;
    logic [4:0]    pkt_idx;
    logic [11:0]   x, y;
    logic          hSync, vSync, VDE, ADE, vid_pre, vid_gb, isl_pre, isl_gb;

    vec_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    int          mx, my, mptr;
    bit          island;
    logic [1:0]  mgrant;

    hdmi_period_scheduler #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .NUM_REQ(NR), .ISL_OFFSET(IO)
    ) dut (
        .clk(clk), .reset(reset), .pkt_req(pkt_req), .pkt_grant(pkt_grant),
        .pkt_idx(pkt_idx), .x(x), .y(y), .hSync(hSync), .vSync(vSync),
        .VDE(VDE), .ADE(ADE), .vid_pre(vid_pre), .vid_gb(vid_gb),
        .isl_pre(isl_pre), .isl_gb(isl_gb)
    );

    always #5 clk = ~clk;

    function automatic vec_t model_vec();
        int   ys;
        logic e_vde, e_hs, e_vs, e_vp, e_vg, e_ip, e_ig, e_ade;
        logic [4:0] e_idx;
        ys    = (my == VT - 1) ? 0 : my + 1;
        e_vde = (mx < HA) && (my < VA);
        e_hs  = (mx >= HA + HF) && (mx <= HA + HF + HS - 1);
        e_vs  = (my >= VA + VF) && (my <= VA + VF + VS - 1);
        e_vp  = (ys < VA) && (mx >= HT - 10) && (mx <= HT - 3);
        e_vg  = (ys < VA) && (mx >= HT - 2);
        e_ip  = island && (mx >= IS) && (mx <= IS + 7);
        e_ig  = island && (((mx >= IS + 8) && (mx <= IS + 9)) ||
                           ((mx >= IS + 42) && (mx <= IS + 43)));
        e_ade = island && (mx >= IS + 10) && (mx <= IS + 41);
        e_idx = e_ade ? 5'(mx - (IS + 10)) : 5'd0;
        return {12'(mx), 12'(my), e_hs, e_vs, e_vde, e_ade, e_vp, e_vg,
                e_ip, e_ig, e_idx, island ? mgrant : 2'b00};
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mptr = 0; island = 1'b0; mgrant = 2'b00;
    endtask

    // Advance the reference by one clock, using the request seen at the edge.
    task automatic model_advance(input logic [NR-1:0] req);
        int k;
        if (mx == HT - 1) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
        end else begin
            mx = mx + 1;
        end
        if (mx == IS + 44) island = 1'b0;
        if (mx == IS && req != '0) begin
            for (int i = 0; i < NR; i++) begin
                k = (mptr + i) % NR;
                if (!island && req[k]) begin
                    island = 1'b1;
                    mgrant = 2'b00;
                    mgrant[k] = 1'b1;
                    mptr = (k + 1) % NR;
                end
            end
            $display("island y=%0d req=%b expected grant=%b", my, req, mgrant);
        end
    endtask

    task automatic check();
        vec_t e, o;
        e = exp_q.pop_front();
        o = {x, y, hSync, vSync, VDE, ADE, vid_pre, vid_gb, isl_pre, isl_gb,
             pkt_idx, pkt_grant};
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL vec x=%0d y=%0d observed=%h expected=%h", mx, my, o, e);
        end
    endtask

    task automatic step();
        logic [NR-1:0] req_at_edge;
        req_at_edge = pkt_req;
        @(posedge clk);
        if (reset) begin
            model_reset();
            exp_q.push_back('0);
        end else begin
            model_advance(req_at_edge);
            exp_q.push_back(model_vec());
        end
        #1 check();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int tx);
        for (int n = 0; n < HT + 2 && mx != tx; n++) step();
        vectors++;
        assert (mx == tx) else begin
            miscompares++;
            $error("FAIL run_to observed=%0d expected=%0d", mx, tx);
        end
    endtask

    initial begin
        reset   = 1'b1;
        pkt_req = '0;
        model_reset();
        run(2);                          // reset state

        reset = 1'b0;
        run(HT * VT);                    // idle frame, no islands

        pkt_req = 2'b01;
        run(HT * 3);                     // single requester

        pkt_req = 2'b11;
        run(HT * VT);                    // alternating grants incl. vblank

        pkt_req = 2'b00;                 // late request waits a line
        run_to(700);
        run_to(IS);
        pkt_req = 2'b01;
        run_to(700);
        run_to(700);

        pkt_req = 2'b11;                 // reach x=660 of a line granted to 0
        for (int l = 0; l < 4 && !(island && mgrant == 2'b01); l++) begin
            run_to(700);
            run_to(660);
        end
        vectors++;
        assert (island && mgrant == 2'b01) else begin
            miscompares++;
            $error("FAIL setup observed island=%0b grant=%b expected 1/01", island, mgrant);
        end
        #2 reset = 1'b1;                 // asynchronous abort mid-island
        model_reset();
        exp_q.push_back('0);
        #1 check();
        run(2);
        reset   = 1'b0;
        pkt_req = 2'b00;
        run_to(IS - 1);
        pkt_req = 2'b11;                 // pointer reset: requester 0 wins
        run(HT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
